// File: rtl/acl2_meas_line_formatter.sv
// acl2_meas_line_formatter: turns each 64-bit ACL2 measurement into an ASCII
// hex text line "X:hhhh Y:hhhh Z:hhhh T:hhhh" + CR LF (or LF) on a byte stream.
//
// Ports:
//   i_clk_20mhz, i_rst_20mhz   clock, async active-high reset
//   i_data_3axis_temp          measurement word, first-received byte at [63:56]
//   i_data_valid               one-cycle strobe for i_data_3axis_temp
//   o_tx_data/o_tx_valid       byte stream to the UART TX FIFO
//   i_tx_ready                 sink accepts the byte this cycle
//   o_busy                     line in flight or a measurement pending
//   o_line_done                one-cycle pulse after the last byte transfers
//   o_drop_count               saturating count of overwritten pending words
module acl2_meas_line_formatter #(
    parameter bit parm_line_end_crlf = 1'b1,
    parameter int parm_drop_cnt_bits = 8
) (
    input  logic                          i_clk_20mhz,
    input  logic                          i_rst_20mhz,
    input  logic [63:0]                   i_data_3axis_temp,
    input  logic                          i_data_valid,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    output logic                          o_busy,
    output logic                          o_line_done,
    output logic [parm_drop_cnt_bits-1:0] o_drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = parm_line_end_crlf ? 5'd28 : 5'd27;

    state_t      state;
    logic [63:0] a;
    logic [63:0] p;
    logic        p_full;
    logic [4:0]  idx;
    logic        xfer;

    assign xfer   = o_tx_valid & i_tx_ready;
    assign o_busy = (state != ST_IDLE) | p_full;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] v;
        v = {4'h0, n};
        return (n < 4'd10) ? (8'h30 + v) : (8'h37 + v);
    endfunction

    // Byte i of the text line for word w. Fields are stored low byte
    // first by the sensor, so each 16-bit value is byte-swapped here.
    function automatic logic [7:0] line_char(input logic [4:0] i,
                                             input logic [63:0] w);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [15:0] t;
        logic [7:0]  c;
        x = {w[55:48], w[63:56]};
        y = {w[39:32], w[47:40]};
        z = {w[23:16], w[31:24]};
        t = {w[7:0],   w[15:8]};
        c = 8'h0A;
        case (i)
            5'd0:  c = 8'h58;
            5'd7:  c = 8'h59;
            5'd14: c = 8'h5A;
            5'd21: c = 8'h54;
            5'd1, 5'd8, 5'd15, 5'd22: c = 8'h3A;
            5'd6, 5'd13, 5'd20:       c = 8'h20;
            5'd2:  c = hex_char(x[15:12]);
            5'd3:  c = hex_char(x[11:8]);
            5'd4:  c = hex_char(x[7:4]);
            5'd5:  c = hex_char(x[3:0]);
            5'd9:  c = hex_char(y[15:12]);
            5'd10: c = hex_char(y[11:8]);
            5'd11: c = hex_char(y[7:4]);
            5'd12: c = hex_char(y[3:0]);
            5'd16: c = hex_char(z[15:12]);
            5'd17: c = hex_char(z[11:8]);
            5'd18: c = hex_char(z[7:4]);
            5'd19: c = hex_char(z[3:0]);
            5'd23: c = hex_char(t[15:12]);
            5'd24: c = hex_char(t[11:8]);
            5'd25: c = hex_char(t[7:4]);
            5'd26: c = hex_char(t[3:0]);
            5'd27: c = parm_line_end_crlf ? 8'h0D : 8'h0A;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            state        <= ST_IDLE;
            a            <= '0;
            p            <= '0;
            p_full       <= 1'b0;
            idx          <= '0;
            o_tx_data    <= 8'h00;
            o_tx_valid   <= 1'b0;
            o_line_done  <= 1'b0;
            o_drop_count <= '0;
        end else begin
            o_line_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_data_valid) begin
                        a          <= i_data_3axis_temp;
                        idx        <= '0;
                        o_tx_data  <= line_char(5'd0, i_data_3axis_temp);
                        o_tx_valid <= 1'b1;
                        state      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (i_data_valid) begin
                        p      <= i_data_3axis_temp;
                        p_full <= 1'b1;
                        if (p_full && (o_drop_count != '1))
                            o_drop_count <= o_drop_count + 1'b1;
                    end
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            o_tx_valid  <= 1'b0;
                            o_line_done <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            idx       <= idx + 5'd1;
                            o_tx_data <= line_char(idx + 5'd1, a);
                        end
                    end
                end
                ST_DONE: begin
                    // A word arriving now is the newest one; it goes
                    // straight into the next line and displaces any
                    // pending word, which is then counted as dropped.
                    if (i_data_valid && p_full && (o_drop_count != '1))
                        o_drop_count <= o_drop_count + 1'b1;
                    if (i_data_valid || p_full) begin
                        a          <= i_data_valid ? i_data_3axis_temp : p;
                        o_tx_data  <= line_char(5'd0,
                                      i_data_valid ? i_data_3axis_temp : p);
                        o_tx_valid <= 1'b1;
                        idx        <= '0;
                        p_full     <= 1'b0;
                        state      <= ST_EMIT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    o_tx_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acl2_meas_line_formatter.sv
// Directed bench for acl2_meas_line_formatter: CRLF and LF-only instances,
// stalls, pending/overrun handling, saturation and mid-line reset.
module tb_acl2_meas_line_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data = '0;
    logic        valid = 1'b0;
    logic        ready = 1'b1;
    logic        valid2 = 1'b0;
    logic        ready2 = 1'b1;
    logic [7:0]  txd, txd2;
    logic        txv, txv2, busy, busy2, ld, ld2;
    logic [7:0]  drop, drop2;

    int total = 0;
    int bad = 0;

    localparam logic [63:0] W1 = 64'h3412_7856_BC9A_F0DE;
    localparam logic [63:0] W2 = 64'hAAAA_5555_0F0F_F0F0;
    localparam logic [63:0] W3 = 64'h1032_5476_98BA_DCFE;

    string e1 = "X:1234 Y:5678 Z:9ABC T:DEF0\015\012";
    string e3 = "X:3210 Y:7654 Z:BA98 T:FEDC\015\012";
    string e0 = "X:0000 Y:0000 Z:0000 T:0000\012";

    always #5 clk = ~clk;

    acl2_meas_line_formatter #(
        .parm_line_end_crlf(1'b1),
        .parm_drop_cnt_bits(8)
    ) dut (
        .i_clk_20mhz(clk),
        .i_rst_20mhz(rst),
        .i_data_3axis_temp(data),
        .i_data_valid(valid),
        .o_tx_data(txd),
        .o_tx_valid(txv),
        .i_tx_ready(ready),
        .o_busy(busy),
        .o_line_done(ld),
        .o_drop_count(drop)
    );

    acl2_meas_line_formatter #(
        .parm_line_end_crlf(1'b0),
        .parm_drop_cnt_bits(8)
    ) dut_lf (
        .i_clk_20mhz(clk),
        .i_rst_20mhz(rst),
        .i_data_3axis_temp(data),
        .i_data_valid(valid2),
        .o_tx_data(txd2),
        .o_tx_valid(txv2),
        .i_tx_ready(ready2),
        .o_busy(busy2),
        .o_line_done(ld2),
        .o_drop_count(drop2)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [63:0] w);
        data  = w;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    // Consume one line, checking every transferred byte. Optional pulses
    // are injected while byte number at1/at2 is presented.
    task automatic run_line(input string exp, input bit stall,
                            input int at1, input logic [63:0] w1,
                            input int at2, input logic [63:0] w2);
        int n = 0;
        int cyc = 0;
        bit held_v = 1'b0;
        logic [7:0] held = '0;
        while (n < exp.len() && cyc < 400) begin
            ready = stall ? (cyc % 3 == 0) : 1'b1;
            valid = 1'b0;
            if (n == at1) begin valid = 1'b1; data = w1; end
            if (n == at2) begin valid = 1'b1; data = w2; end
            chk("done_mid_line", ld, 1'b0);
            if (held_v) begin
                chk("stall_data", txd, held);
                chk("stall_valid", txv, 1'b1);
            end
            held_v = 1'b0;
            if (txv && ready) begin
                chk($sformatf("byte%0d", n), txd, exp[n]);
                n++;
            end else if (txv) begin
                held   = txd;
                held_v = 1'b1;
            end
            step();
            cyc++;
        end
        valid = 1'b0;
        ready = 1'b1;
        if (n < exp.len()) chk("line_timeout", n, exp.len());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", txv, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", ld, 1'b0);
        chk("rst_data", txd, 8'h00);
        chk("rst_drop", drop, 8'd0);
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", txv, 1'b0);
        chk("init_data", txd, 8'h00);
        chk("init_done", ld, 1'b0);
        chk("init_busy", busy, 1'b0);
        chk("init_drop", drop, 8'd0);
        rst = 1'b0;
        step();
        chk("idle_valid", txv, 1'b0);

        // basic line, ready held high
        pulse(W1);
        chk("latency_valid", txv, 1'b1);
        chk("latency_x", txd, 8'h58);
        chk("busy_emit", busy, 1'b1);
        run_line(e1, 1'b0, -1, '0, -1, '0);
        chk("done_pulse", ld, 1'b1);
        chk("done_valid", txv, 1'b0);
        chk("done_busy", busy, 1'b1);
        step();
        chk("done_once", ld, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid2", txv, 1'b0);

        // same line under 1,0,0 ready stalls
        pulse(W1);
        run_line(e1, 1'b1, -1, '0, -1, '0);
        chk("stall_done", ld, 1'b1);
        step();
        chk("stall_idle", busy, 1'b0);

        // two pulses mid-line: W2 dropped, W3 emitted next
        pulse(W1);
        run_line(e1, 1'b0, 5, W2, 10, W3);
        chk("ovr_done1", ld, 1'b1);
        chk("ovr_busy", busy, 1'b1);
        step();
        chk("ovr_next_valid", txv, 1'b1);
        run_line(e3, 1'b0, -1, '0, -1, '0);
        chk("ovr_done2", ld, 1'b1);
        chk("ovr_drop", drop, 8'd1);
        step();
        chk("ovr_idle", busy, 1'b0);

        do_reset();

        // pulse on the final LF transfer
        pulse(W1);
        run_line(e1, 1'b0, 28, W3, -1, '0);
        chk("edge_done", ld, 1'b1);
        step();
        chk("edge_next_valid", txv, 1'b1);
        run_line(e3, 1'b0, -1, '0, -1, '0);
        chk("edge_drop", drop, 8'd0);
        step();

        // saturation with the sink stalled
        ready = 1'b0;
        data  = W1;
        valid = 1'b1;
        step();
        step();
        chk("sat_fill", drop, 8'd0);
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 254) chk("sat_254", drop, 8'd254);
            if (i == 255) chk("sat_255", drop, 8'd255);
        end
        valid = 1'b0;
        chk("sat_300", drop, 8'd255);
        chk("sat_hold_valid", txv, 1'b1);
        chk("sat_hold_x", txd, 8'h58);
        chk("sat_busy", busy, 1'b1);
        ready = 1'b1;

        do_reset();

        // reset at idx 12
        pulse(W1);
        repeat (12) step();
        chk("idx12_char", txd, 8'h38);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", txv, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", ld, 1'b0);
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("post_rst_quiet", txv, 1'b0);
        chk("post_rst_done", ld, 1'b0);
        pulse(W3);
        chk("fresh_x", txd, 8'h58);
        run_line(e3, 1'b0, -1, '0, -1, '0);
        chk("fresh_done", ld, 1'b1);
        step();

        // LF-only instance, all-zero word
        data   = '0;
        valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        chk("lf_busy", busy2, 1'b1);
        for (int i = 0; i < 28; i++) begin
            chk($sformatf("lf_valid%0d", i), txv2, 1'b1);
            chk($sformatf("lf_byte%0d", i), txd2, e0[i]);
            step();
        end
        chk("lf_done", ld2, 1'b1);
        chk("lf_end_valid", txv2, 1'b0);
        step();
        chk("lf_idle", busy2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
